apb_master_bridge: RTL and testbench

Single-outstanding APB4 requester. It converts a valid/ready command stream into APB SETUP/ACCESS transfers, then returns read data and the error status on a valid/ready response stream. The block sits between an internal bus client and an APB segment of slave register blocks. A programmable timeout stops a hung slave from stalling the client.

---
 rtl/apb_pkg.sv | 26 ++
 rtl/apb_master_bridge.sv | 110 +++++++++++
 tb/tb_apb_master_bridge.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB requester types: FSM state encoding and the command record.
package apb_pkg;

   localparam int APB_ADDR_WIDTH = 32;
   localparam int APB_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } apb_master_state_e;

   typedef struct packed {
      logic [APB_ADDR_WIDTH-1:0]   addr;
      logic                        write;
      logic [APB_DATA_WIDTH-1:0]   wdata;
      logic [APB_DATA_WIDTH/8-1:0] strb;
   } apb_cmd_t;

   // Wait-counter width able to hold 0..n, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB4 requester: cmd stream -> SETUP/ACCESS -> rsp stream,
// with an optional ACCESS-phase timeout to survive a hung slave.
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
   parameter int DATA_WIDTH     = APB_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    pclk,
   input  logic                    preset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic                    cmd_write,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_strb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,
   output logic                    rsp_timeout,
   output logic [ADDR_WIDTH-1:0]   paddr,
   output logic                    pwrite,
   output logic [DATA_WIDTH-1:0]   pwdata,
   output logic [DATA_WIDTH/8-1:0] pstrb,
   output logic                    psel,
   output logic                    penable,
   input  logic [DATA_WIDTH-1:0]   prdata,
   input  logic                    pready,
   input  logic                    pslverr
);

   localparam int              CW       = cnt_width(TIMEOUT_CYCLES);
   localparam bit              TO_EN    = (TIMEOUT_CYCLES != 0);
   localparam logic [CW-1:0]   CNT_LAST = TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

   apb_master_state_e state;
   logic [CW-1:0]     cnt;

   // Only IDLE can take a new command; one transfer in flight at a time.
   assign cmd_ready = (state == IDLE);

   // Transfer FSM; all APB and response outputs are registered here.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state       <= IDLE;
         cnt         <= '0;
         paddr       <= '0;
         pwrite      <= 1'b0;
         pwdata      <= '0;
         pstrb       <= '0;
         psel        <= 1'b0;
         penable     <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  paddr  <= cmd_addr;
                  pwrite <= cmd_write;
                  pwdata <= cmd_wdata;
                  // strobes are meaningless on reads, drive them low
                  pstrb  <= cmd_write ? cmd_strb : '0;
                  psel   <= 1'b1;
                  state  <= SETUP;
               end
            end
            SETUP: begin
               penable <= 1'b1;
               cnt     <= '0;
               state   <= ACCESS;
            end
            ACCESS: begin
               // pready wins over a timeout expiring in the same cycle
               if (pready) begin
                  rsp_rdata   <= pwrite ? '0 : prdata;
                  rsp_err     <= pslverr;
                  rsp_timeout <= 1'b0;
                  rsp_valid   <= 1'b1;
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  state       <= RESP;
               end else if (TO_EN && cnt == CNT_LAST) begin
                  rsp_rdata   <= '0;
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b1;
                  rsp_valid   <= 1'b1;
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  state       <= RESP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: behavioural APB slave plus a register-file
// reference model predicting every response and its cycle of arrival.
module tb_apb_master_bridge;
   import apb_pkg::*;

   localparam int TO = 16;

   logic        pclk, preset;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_strb;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [31:0] paddr, pwdata, prdata;
   logic        pwrite, psel, penable, pready, pslverr;
   logic [3:0]  pstrb;

   int errors = 0;
   int checks = 0;

   // slave configuration and storage
   int          s_waits = 0;
   bit          s_stall = 0;
   logic [31:0] smem    [4];
   // reference model register file
   logic [31:0] ref_mem [4];

   apb_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
      .pclk(pclk), .preset(preset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
      .psel(psel), .penable(penable),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // APB slave: 4 registers at 0x0..0xC, pslverr above 0x0F, junk on idle pins
   initial begin
      int acc;
      int idx;
      bit err;
      acc = 0;
      pready = 1'b0; pslverr = 1'b0; prdata = '0;
      for (int i = 0; i < 4; i++) smem[i] = '0;
      forever begin
         @(negedge pclk);
         if (psel === 1'b1 && penable === 1'b1) begin
            if (s_stall || acc < s_waits) begin
               pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom; acc++;
            end else begin
               idx = int'(paddr[3:2]);
               err = (paddr >= 32'h10);
               pready = 1'b1; pslverr = err;
               if (pwrite) begin
                  prdata = $urandom;
                  if (!err)
                     for (int b = 0; b < 4; b++)
                        if (pstrb[b]) smem[idx][8*b +: 8] = pwdata[8*b +: 8];
               end else begin
                  prdata = err ? 32'h0 : smem[idx];
               end
            end
         end else begin
            pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom; acc = 0;
         end
      end
   end

   // One complete transfer: predicts response/latency, checks APB phases,
   // holds rsp_ready low for 'hold' cycles, then consumes the response.
   task automatic xfer(input apb_cmd_t c, input int waits, input bit stall,
                       input int hold, input string tag);
      logic [31:0] exp_rd, held;
      logic [3:0]  exp_strb;
      bit          exp_err, exp_to, done;
      int          exp_lat, k;
      exp_strb = c.write ? c.strb : 4'h0;
      if (stall) begin
         exp_err = 1; exp_to = 1; exp_rd = '0; exp_lat = TO + 2;
      end else begin
         exp_to  = 0;
         exp_lat = 3 + waits;
         exp_err = (c.addr >= 32'h10);
         exp_rd  = (c.write || exp_err) ? 32'h0 : ref_mem[c.addr[3:2]];
         if (c.write && !exp_err)
            for (int b = 0; b < 4; b++)
               if (c.strb[b]) ref_mem[c.addr[3:2]][8*b +: 8] = c.wdata[8*b +: 8];
      end
      s_waits = waits; s_stall = stall;

      @(negedge pclk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++; $display("FAIL %s idle_ready: got %b want 1", tag, cmd_ready);
      end
      cmd_valid = 1'b1; cmd_addr = c.addr; cmd_write = c.write;
      cmd_wdata = c.wdata; cmd_strb = c.strb;

      @(negedge pclk);  // cycle T+1
      cmd_valid = 1'b0; cmd_addr = $urandom; cmd_write = 1'($urandom);
      cmd_wdata = $urandom; cmd_strb = 4'($urandom);
      k = 1;
      checks++;
      if (psel !== 1'b1 || penable !== 1'b0 || cmd_ready !== 1'b0 || paddr !== c.addr ||
          pwrite !== c.write || pwdata !== c.wdata || pstrb !== exp_strb) begin
         errors++;
         $display("FAIL %s setup: got psel=%b pen=%b rdy=%b addr=%h wr=%b wd=%h strb=%h want 1 0 0 %h %b %h %h",
                  tag, psel, penable, cmd_ready, paddr, pwrite, pwdata, pstrb,
                  c.addr, c.write, c.wdata, exp_strb);
      end

      done = 0;
      while (!done && k < 40) begin
         @(negedge pclk);
         k++;
         if (rsp_valid === 1'b1) done = 1;
         else begin
            checks++;
            if (psel !== 1'b1 || penable !== 1'b1 || paddr !== c.addr ||
                pwrite !== c.write || pwdata !== c.wdata || pstrb !== exp_strb) begin
               errors++;
               $display("FAIL %s access_k%0d: got psel=%b pen=%b addr=%h wd=%h strb=%h want 1 1 %h %h %h",
                        tag, k, psel, penable, paddr, pwdata, pstrb, c.addr, c.wdata, exp_strb);
            end
         end
      end

      checks++;
      if (!done || k != exp_lat) begin
         errors++; $display("FAIL %s latency: got %0d want %0d (done=%0b)", tag, k, exp_lat, done);
      end
      if (!done) return;

      checks++;
      if (rsp_rdata !== exp_rd || rsp_err !== exp_err || rsp_timeout !== exp_to ||
          psel !== 1'b0 || penable !== 1'b0 || cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s rsp: got rd=%h err=%b to=%b psel=%b pen=%b rdy=%b want %h %b %b 0 0 0",
                  tag, rsp_rdata, rsp_err, rsp_timeout, psel, penable, cmd_ready,
                  exp_rd, exp_err, exp_to);
      end
      held = rsp_rdata;

      repeat (hold) begin
         @(negedge pclk);
         checks++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== held || rsp_err !== exp_err || psel !== 1'b0) begin
            errors++;
            $display("FAIL %s rsp_hold: got v=%b rd=%h err=%b psel=%b want 1 %h %b 0",
                     tag, rsp_valid, rsp_rdata, rsp_err, psel, held, exp_err);
         end
      end

      rsp_ready = 1'b1;
      @(negedge pclk);
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s rsp_done: got v=%b rdy=%b want 0 1", tag, rsp_valid, cmd_ready);
      end
   endtask

   task automatic test_reset();
      preset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
      cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0; cmd_strb = '0;
      for (int i = 0; i < 4; i++) ref_mem[i] = '0;
      #3;
      checks++;
      if (psel !== 0 || penable !== 0 || rsp_valid !== 0 || rsp_err !== 0 || rsp_timeout !== 0 ||
          paddr !== 0 || pwdata !== 0 || pstrb !== 0 || pwrite !== 0 || rsp_rdata !== 0 ||
          cmd_ready !== 1) begin
         errors++;
         $display("FAIL reset_state: got psel=%b pen=%b v=%b err=%b to=%b addr=%h wd=%h strb=%h wr=%b rd=%h rdy=%b want all 0, rdy=1",
                  psel, penable, rsp_valid, rsp_err, rsp_timeout, paddr, pwdata, pstrb, pwrite, rsp_rdata, cmd_ready);
      end
      repeat (2) @(negedge pclk);
      preset = 1'b0;
   endtask

   task automatic test_write_read();
      xfer('{addr: 32'h4, write: 1'b1, wdata: 32'hDEADBEEF, strb: 4'hF}, 0, 0, 0, "wr_deadbeef");
      xfer('{addr: 32'h4, write: 1'b0, wdata: 32'h12345678, strb: 4'hF}, 0, 0, 0, "rd_deadbeef");
   endtask

   task automatic test_strobe();
      xfer('{addr: 32'h4, write: 1'b1, wdata: 32'h0000AAAA, strb: 4'h3}, 0, 0, 0, "wr_strb3");
      xfer('{addr: 32'h4, write: 1'b0, wdata: 32'h0, strb: 4'hF}, 0, 0, 1, "rd_deadaaaa");
      checks++;
      if (ref_mem[1] !== 32'hDEADAAAA) begin
         errors++; $display("FAIL strobe_model: got %h want DEADAAAA", ref_mem[1]);
      end
   endtask

   task automatic test_slverr();
      xfer('{addr: 32'h40, write: 1'b0, wdata: 32'h0, strb: 4'h0}, 0, 0, 0, "rd_slverr");
      xfer('{addr: 32'h40, write: 1'b1, wdata: 32'h5555_5555, strb: 4'hF}, 1, 0, 0, "wr_slverr");
   endtask

   task automatic test_wait_states();
      xfer('{addr: 32'h8, write: 1'b1, wdata: 32'hCAFE_F00D, strb: 4'hF}, 3, 0, 0, "wr_wait3");
      xfer('{addr: 32'h8, write: 1'b0, wdata: 32'h0, strb: 4'h0}, 3, 0, 2, "rd_wait3");
   endtask

   task automatic test_timeout();
      xfer('{addr: 32'hC, write: 1'b0, wdata: 32'h0, strb: 4'h0}, 0, 1, 0, "rd_timeout");
      xfer('{addr: 32'hC, write: 1'b1, wdata: 32'h1111_2222, strb: 4'hF}, 0, 1, 0, "wr_timeout");
      // completion on the very cycle the timeout would fire
      xfer('{addr: 32'h0, write: 1'b1, wdata: 32'hA5A5_5A5A, strb: 4'hF}, TO - 1, 0, 0, "wr_at_limit");
      xfer('{addr: 32'h0, write: 1'b0, wdata: 32'h0, strb: 4'h0}, TO - 1, 0, 0, "rd_at_limit");
   endtask

   task automatic test_reset_mid();
      s_stall = 1;
      @(negedge pclk);
      cmd_valid = 1'b1; cmd_addr = 32'h4; cmd_write = 1'b0; cmd_wdata = '0; cmd_strb = '0;
      @(negedge pclk);
      cmd_valid = 1'b0;
      repeat (3) @(negedge pclk);
      #2 preset = 1'b1;
      #1;
      checks++;
      if (psel !== 0 || penable !== 0 || rsp_valid !== 0 || cmd_ready !== 1 || paddr !== 0) begin
         errors++;
         $display("FAIL reset_mid: got psel=%b pen=%b v=%b rdy=%b addr=%h want 0 0 0 1 0",
                  psel, penable, rsp_valid, cmd_ready, paddr);
      end
      @(negedge pclk);
      preset = 1'b0; s_stall = 0;
      repeat (20) begin
         @(negedge pclk);
         checks++;
         if (rsp_valid !== 0 || psel !== 0 || cmd_ready !== 1) begin
            errors++;
            $display("FAIL reset_mid_quiet: got v=%b psel=%b rdy=%b want 0 0 1", rsp_valid, psel, cmd_ready);
         end
      end
      xfer('{addr: 32'h4, write: 1'b0, wdata: 32'h0, strb: 4'h0}, 0, 0, 0, "rd_after_reset");
   endtask

   task automatic test_back_to_back();
      apb_cmd_t c;
      logic [31:0] addrs [5];
      addrs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h40};
      for (int n = 0; n < 40; n++) begin
         c.addr  = addrs[$urandom_range(0, 4)];
         c.write = 1'($urandom);
         c.wdata = $urandom;
         c.strb  = 4'($urandom);
         xfer(c, $urandom_range(0, 3), 0, $urandom_range(0, 2), "random");
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_strobe();
      test_slverr();
      test_wait_states();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
